// File: rtl/apb_sample_fifo.sv
// APB3 completer buffering fabric samples; firmware drains them through DATA reads.
// Optional threshold interrupt is built only when WUBSUIT_APB_IRQ_EN is defined.
`timescale 1ns/1ps
module apb_sample_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 16
) (
    input  logic              SYSCLK,
    input  logic              SYSRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [4:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              SAMPLE_VALID,
    input  logic [DATA_W-1:0] SAMPLE_DATA,
    output logic              IRQ
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_THRESH  = 3'd3;
    localparam logic [2:0] REG_IRQ_CLR = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_e;
    state_e state_q, state_d;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [2:0]            reg_q;
    logic                  wr_q;
    logic [31:0]           rdata_q;
    logic                  rd_err_q;
    logic                  enable_q, flush_q, ovf_q;
    logic                  empty, full, setup, access, wr_fire, push, pop;
    logic [8:0]            level9;
    logic [31:0]           status_rd, ctrl_rd, thresh_rd;
    logic                  unused_ok;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign level9    = 9'(level_q);
    assign setup     = (state_q == ST_IDLE) && PSEL && !PENABLE;
    assign access    = (state_q == ST_ACCESS) && PSEL && PENABLE;
    assign wr_fire   = access && wr_q;
    // rd_err_q holds the empty flag sampled in WAIT, so a late push never feeds this read
    assign pop       = access && !wr_q && (reg_q == REG_DATA) && !rd_err_q;
    assign push      = SAMPLE_VALID && enable_q && !full && !flush_q;
    assign status_rd = {13'd0, ovf_q, full, empty, 7'd0, level9};
    assign unused_ok = ^{PADDR[1:0], PWDATA};

`ifdef WUBSUIT_APB_IRQ_EN
    logic       irq_en_q, irq_q;
    logic [8:0] thresh_q;

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            irq_en_q <= 1'b0;
            thresh_q <= 9'd1;
            irq_q    <= 1'b0;
        end else begin
            if (wr_fire && reg_q == REG_CTRL)   irq_en_q <= PWDATA[2];
            if (wr_fire && reg_q == REG_THRESH) thresh_q <= PWDATA[8:0];
            irq_q <= irq_en_q && enable_q && (level9 >= thresh_q);
        end
    end

    assign IRQ       = irq_q;
    assign ctrl_rd   = {29'd0, irq_en_q, 1'b0, enable_q};
    assign thresh_rd = {23'd0, thresh_q};
`else
    assign IRQ       = 1'b0;
    assign ctrl_rd   = {31'd0, enable_q};
    assign thresh_rd = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (setup) state_d = (PADDR[4:2] == REG_DATA && !PWRITE) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   state_d = PSEL ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (state_q == ST_ACCESS) begin
            PREADY = 1'b1;
            case (reg_q)
                REG_DATA: begin
                    PSLVERR = !wr_q && rd_err_q;
                    if (!wr_q && !rd_err_q) PRDATA = rdata_q;
                end
                REG_STATUS:       if (!wr_q) PRDATA = status_rd;
                REG_CTRL:         if (!wr_q) PRDATA = ctrl_rd;
                REG_THRESH:       if (!wr_q) PRDATA = thresh_rd;
                3'd5, 3'd6, 3'd7: PSLVERR = 1'b1;
                default:          PRDATA = '0;
            endcase
        end
    end

    always_comb begin
        level_d = level_q;
        if (flush_q)             level_d = '0;
        else if (push && !pop)   level_d = level_q + LVL_W'(1);
        else if (pop && !push)   level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge SYSCLK) begin
        if (push) mem_q[wr_ptr_q] <= SAMPLE_DATA;
    end

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            state_q  <= ST_IDLE;
            reg_q    <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            rd_err_q <= 1'b0;
            enable_q <= 1'b0;
            flush_q  <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            flush_q <= wr_fire && (reg_q == REG_CTRL) && PWDATA[1];
            if (setup) begin
                reg_q <= PADDR[4:2];
                wr_q  <= PWRITE;
            end
            if (state_q == ST_WAIT) begin
                rdata_q  <= 32'(mem_q[rd_ptr_q]);
                rd_err_q <= empty;
            end
            if (wr_fire && reg_q == REG_CTRL) enable_q <= PWDATA[0];
            if (flush_q) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            if (SAMPLE_VALID && enable_q && full)
                ovf_q <= 1'b1;
            else if (wr_fire && reg_q == REG_IRQ_CLR && PWDATA[18])
                ovf_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_apb_sample_fifo.sv
// Directed plus randomized bench for apb_sample_fifo against a queue-based reference model.
`timescale 1ns/1ps
module tb_apb_sample_fifo;
    localparam int DEPTH = 16;

    logic        SYSCLK, SYSRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        SAMPLE_VALID;
    logic [15:0] SAMPLE_DATA;
    logic        IRQ;

    apb_sample_fifo #(.DEPTH_LOG2(4), .DATA_W(16)) dut (
        .SYSCLK(SYSCLK), .SYSRESET(SYSRESET),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_DATA(SAMPLE_DATA), .IRQ(IRQ)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    int errors = 0;
    int checks = 0;

    // reference model
    logic [15:0] mq[$];
    logic        m_en, m_ovf, m_irq_en;
    int          m_thresh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_en = 1'b0; m_ovf = 1'b0; m_irq_en = 1'b0; m_thresh = 1;
    endtask

    task automatic model_push(input logic [15:0] d);
        if (m_en) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'h0;
        s[8:0] = 9'(mq.size());
        s[16]  = (mq.size() == 0);
        s[17]  = (mq.size() == DEPTH);
        s[18]  = m_ovf;
        return s;
    endfunction

    function automatic logic exp_irq();
`ifdef WUBSUIT_APB_IRQ_EN
        return m_irq_en && m_en && (mq.size() >= m_thresh);
`else
        return 1'b0;
`endif
    endfunction

    task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                       input logic pa, input logic [15:0] pd,
                       output logic [31:0] rd, output logic er, output int waits);
        @(posedge SYSCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(posedge SYSCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        while (PREADY !== 1'b1 && waits < 8) begin
            @(posedge SYSCLK); #1;
            waits++;
        end
        rd = PRDATA; er = PSLVERR;
        if (pa) begin SAMPLE_VALID = 1'b1; SAMPLE_DATA = pd; end
        @(posedge SYSCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        if (pa) SAMPLE_VALID = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp_d,
                          input logic exp_e);
        logic [31:0] rd; logic er; int w;
        apb(1'b0, addr, 32'h0, 1'b0, 16'h0, rd, er, w);
        chk({tag, "_dat"}, rd, exp_d);
        chk({tag, "_err"}, 32'(er), 32'(exp_e));
        chk({tag, "_wait"}, 32'(w), 32'd0);
    endtask

    task automatic wr_chk(input string tag, input logic [4:0] addr, input logic [31:0] wd,
                          input logic exp_e);
        logic [31:0] rd; logic er; int w;
        apb(1'b1, addr, wd, 1'b0, 16'h0, rd, er, w);
        chk({tag, "_err"}, 32'(er), 32'(exp_e));
        chk({tag, "_wait"}, 32'(w), 32'd0);
    endtask

    task automatic ctrl_wr(input logic [31:0] v);
        wr_chk("ctrl_wr", 5'h08, v, 1'b0);
        m_en = v[0];
`ifdef WUBSUIT_APB_IRQ_EN
        m_irq_en = v[2];
`endif
        if (v[1]) mq.delete();
    endtask

    task automatic data_chk(input string tag, input logic pa, input logic [15:0] pd);
        logic [31:0] rd, exp_d; logic er, exp_e; int w;
        if (mq.size() == 0) begin exp_d = 32'h0; exp_e = 1'b1; end
        else begin exp_d = {16'h0, mq.pop_front()}; exp_e = 1'b0; end
        apb(1'b0, 5'h00, 32'h0, pa, pd, rd, er, w);
        if (pa) model_push(pd);
        chk({tag, "_dat"}, rd, exp_d);
        chk({tag, "_err"}, 32'(er), 32'(exp_e));
        chk({tag, "_wait"}, 32'(w), 32'd1);
    endtask

    task automatic push_n(input int n, input logic rnd, input logic [15:0] base);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 16'($urandom) : base + 16'(i);
            @(posedge SYSCLK); #1;
            SAMPLE_VALID = 1'b1; SAMPLE_DATA = d;
            model_push(d);
        end
        @(posedge SYSCLK); #1;
        SAMPLE_VALID = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        SAMPLE_VALID = 0; SAMPLE_DATA = '0;
        model_reset();
        SYSRESET = 1'b1;
        #1;
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_irq", 32'(IRQ), 32'd0);
        repeat (3) @(posedge SYSCLK);
        #1 SYSRESET = 1'b0;

        rd_chk("status_rst", 5'h04, 32'h0001_0000, 1'b0);
        rd_chk("ctrl_rst", 5'h08, 32'h0, 1'b0);
`ifdef WUBSUIT_APB_IRQ_EN
        rd_chk("thresh_rst", 5'h0C, 32'h1, 1'b0);
`else
        rd_chk("thresh_rst", 5'h0C, 32'h0, 1'b0);
`endif

        // basic push / drain
        ctrl_wr(32'h1);
        push_n(1, 1'b0, 16'h1234);
        push_n(1, 1'b0, 16'hBEEF);
        data_chk("data1", 1'b0, 16'h0);
        data_chk("data2", 1'b0, 16'h0);
        rd_chk("status_drained", 5'h04, 32'h0001_0000, 1'b0);

        // overflow at full
        push_n(17, 1'b0, 16'h0100);
        rd_chk("status_ovf", 5'h04, 32'h0006_0010, 1'b0);
        wr_chk("irq_clr", 5'h10, 32'h0004_0000, 1'b0);
        m_ovf = 1'b0;
        rd_chk("status_clr", 5'h04, 32'h0002_0010, 1'b0);
        for (int i = 0; i < 16; i++) data_chk("drain", 1'b0, 16'h0);

        // empty read and unmapped accesses
        data_chk("empty_rd", 1'b0, 16'h0);
        rd_chk("status_empty", 5'h04, exp_status(), 1'b0);
        rd_chk("unmapped_rd", 5'h1C, 32'h0, 1'b1);
        wr_chk("unmapped_wr", 5'h14, 32'hFFFF_FFFF, 1'b1);
        wr_chk("data_wr", 5'h00, 32'hFFFF_FFFF, 1'b0);
        rd_chk("irqclr_rd", 5'h10, 32'h0, 1'b0);

        ctrl_wr(32'h7);
`ifdef WUBSUIT_APB_IRQ_EN
        rd_chk("ctrl_rb", 5'h08, 32'h5, 1'b0);
`else
        rd_chk("ctrl_rb", 5'h08, 32'h1, 1'b0);
`endif

        // threshold interrupt
        ctrl_wr(32'h5);
        wr_chk("thresh_wr", 5'h0C, 32'h3, 1'b0);
`ifdef WUBSUIT_APB_IRQ_EN
        m_thresh = 3;
        rd_chk("thresh_rb", 5'h0C, 32'h3, 1'b0);
`else
        rd_chk("thresh_rb", 5'h0C, 32'h0, 1'b0);
`endif
        push_n(3, 1'b0, 16'h0300);
        chk("irq_pre", 32'(IRQ), 32'd0);
        @(posedge SYSCLK); #1;
        chk("irq_rise", 32'(IRQ), 32'(exp_irq()));
        data_chk("irq_pop", 1'b0, 16'h0);
        @(posedge SYSCLK); #1;
        chk("irq_fall", 32'(IRQ), 32'd0);
`ifdef WUBSUIT_APB_IRQ_EN
        wr_chk("thresh0", 5'h0C, 32'h0, 1'b0);
        m_thresh = 0;
        @(posedge SYSCLK); #1;
        chk("irq_thresh0", 32'(IRQ), 32'd1);
`endif

        // simultaneous pop and push at level 4
        while (mq.size() != 0) data_chk("pre_conc", 1'b0, 16'h0);
        push_n(4, 1'b0, 16'h0400);
        data_chk("conc", 1'b1, 16'hA5A5);
        rd_chk("status_conc", 5'h04, 32'h0001_0000 & 32'h0 | exp_status(), 1'b0);
        chk("conc_level", {23'h0, exp_status()[8:0]}, 32'd4);

        // disabled pushes vanish silently
        ctrl_wr(32'h0);
        push_n(3, 1'b1, 16'h0);
        rd_chk("status_dis", 5'h04, exp_status(), 1'b0);

        // flush with SAMPLE_VALID held high
        ctrl_wr(32'h1);
        push_n(3, 1'b1, 16'h0);
        @(posedge SYSCLK); #1;
        SAMPLE_VALID = 1'b1; SAMPLE_DATA = 16'h7777;
        ctrl_wr(32'h3);
        @(posedge SYSCLK); #1;
        SAMPLE_VALID = 1'b0;
        mq.delete();
        rd_chk("status_flush", 5'h04, 32'h0001_0000, 1'b0);
        rd_chk("ctrl_flush", 5'h08, 32'h1, 1'b0);

        // randomized traffic
        begin
            logic [31:0] tv;
            tv = 32'($urandom_range(0, 17));
            wr_chk("rnd_thresh", 5'h0C, tv, 1'b0);
`ifdef WUBSUIT_APB_IRQ_EN
            m_thresh = int'(tv);
`endif
        end
        ctrl_wr(32'h5);
        for (int it = 0; it < 80; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4) push_n($urandom_range(1, 6), 1'b1, 16'h0);
            else if (op < 8) data_chk("rnd_data", 1'b0, 16'h0);
            else if (op == 8) rd_chk("rnd_status", 5'h04, exp_status(), 1'b0);
            else if ($urandom_range(0, 1) == 1) begin
                wr_chk("rnd_irqclr", 5'h10, 32'h0004_0000, 1'b0);
                m_ovf = 1'b0;
            end else ctrl_wr({29'h0, 1'b1, 1'b0, ($urandom_range(0, 3) != 0)});
            @(posedge SYSCLK); #1;
            chk("rnd_irq", 32'(IRQ), 32'(exp_irq()));
        end
        rd_chk("rnd_status_end", 5'h04, exp_status(), 1'b0);

        // reset during the wait state of a DATA read
        ctrl_wr(32'h1);
        push_n(3, 1'b1, 16'h0);
        @(posedge SYSCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 5'h00;
        @(posedge SYSCLK); #1;
        PENABLE = 1'b1;
        chk("wait_pready", 32'(PREADY), 32'd0);
        chk("wait_prdata", PRDATA, 32'h0);
        SYSRESET = 1'b1;
        #1;
        chk("rstw_pready", 32'(PREADY), 32'd0);
        @(posedge SYSCLK); #1;
        chk("rstw_pready2", 32'(PREADY), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        SYSRESET = 1'b0;
        model_reset();
        rd_chk("status_rstw", 5'h04, 32'h0001_0000, 1'b0);
        rd_chk("ctrl_rstw", 5'h08, 32'h0, 1'b0);
        chk("irq_rstw", 32'(IRQ), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
